// File: rtl/ram512_arbiter.sv
// Round-robin two-port arbiter and zero-initialiser in front of a single-port ram512.
// Sweeps the RAM with zeros after reset (or on clear_start), then serves A and B one access per cycle.
module ram512_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    output logic                  busy,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,

    output logic [DATA_WIDTH-1:0] ram_in,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_load,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    typedef enum logic [1:0] {START, CLEAR, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  last;       // 0 = A won last, 1 = B won last
    logic                  a_win;
    logic                  b_win;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        a_win = (state == RUN) && a_req && (!b_req || last);
        b_win = (state == RUN) && b_req && (!a_req || !last);
    end

    assign a_gnt = a_win;
    assign b_gnt = b_win;
    assign busy  = (state != RUN);

    // Idle cycles keep the previous address so the RAM sees no spurious change.
    always_comb begin
        ram_load    = 1'b0;
        ram_in      = '0;
        ram_address = addr_hold;
        case (state)
            CLEAR: begin
                ram_load    = 1'b1;
                ram_address = cnt;
            end
            RUN: begin
                if (a_win) begin
                    ram_load    = a_we;
                    ram_in      = a_wdata;
                    ram_address = a_addr;
                end else if (b_win) begin
                    ram_load    = b_we;
                    ram_in      = b_wdata;
                    ram_address = b_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= START;
            cnt       <= '0;
            addr_hold <= '0;
            last      <= 1'b1;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            addr_hold <= ram_address;
            a_rvalid  <= a_win && !a_we;
            b_rvalid  <= b_win && !b_we;
            if (a_win && !a_we)
                a_rdata <= ram_out;
            if (b_win && !b_we)
                b_rdata <= ram_out;
            if (a_win)
                last <= 1'b0;
            else if (b_win)
                last <= 1'b1;

            case (state)
                START: state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: if (clear_start) state <= CLEAR;
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed bench for ram512_arbiter with a behavioural ram512 attached.
module tb_ram512_arbiter;

    localparam int DW = 16;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_start = 1'b0;
    logic          busy;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] ram_in, ram_out;
    logic [AW-1:0] ram_address;
    logic          ram_load;

    logic          fill = 1'b0;
    logic [DW-1:0] mem [512];
    logic [11:0]   pat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram512_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // ram512: combinational read, write on rising edge; fill preloads garbage
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'hA5A5 ^ 16'(i);
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic int nz();
        int c = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== 16'h0000) c++;
        return c;
    endfunction

    // Samples every cycle of a sweep; with_start adds the leading START cycle.
    task automatic sweep(input string tag, input int with_start);
        int nbusy = 0, nload = 0, nerr = 0, ngnt = 0;
        for (int i = 0; i < 512 + with_start; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (a_gnt || b_gnt) ngnt++;
            if (i < with_start) begin
                if (ram_load) nerr++;
            end else begin
                if (ram_load) nload++;
                if (ram_address !== AW'(i - with_start) || ram_in !== '0) nerr++;
            end
        end
        chk({tag, "_busy"}, nbusy, 512 + with_start);
        chk({tag, "_load"}, nload, 512);
        chk({tag, "_addr"}, nerr, 0);
        chk({tag, "_nogrant"}, ngnt, 0);
    endtask

    initial begin
        // reset with garbage in the RAM and A already requesting
        fill = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd0;
        tick;
        fill = 1'b0;
        smp;
        chk("rst_outs", {busy, ram_load, a_gnt, b_gnt, a_rvalid, b_rvalid}, 6'b100000);
        chk("rst_addr", ram_address, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        tick;
        rst_n = 1'b1;
        sweep("sweep0", 1);
        smp;
        chk("run_busy", busy, 0);
        chk("first_gnt", {a_gnt, b_gnt}, 2'b10);
        chk("mem_zero0", nz(), 0);
        tick;
        a_req = 1'b0;
        smp;
        chk("first_rd", {a_rvalid, a_rdata}, {1'b1, 16'h0000});

        // A writes then reads 300
        tick;
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'd300; a_wdata = 16'h1234;
        smp;
        chk("wr_gnt", {a_gnt, b_gnt}, 2'b10);
        tick;
        a_we = 1'b0;
        smp;
        chk("rd_gnt", {a_gnt, b_gnt}, 2'b10);
        chk("wr_no_rv", a_rvalid, 0);
        tick;
        a_req = 1'b0;
        smp;
        chk("rd_data", a_rdata, 16'h1234);
        chk("rd_rv", {a_rvalid, b_rvalid}, 2'b10);
        tick;
        smp;
        chk("rv_pulse", a_rvalid, 0);
        chk("rd_hold", a_rdata, 16'h1234);

        // B writes 5 in cycle N, A reads 5 in N+1
        tick;
        b_req = 1'b1; b_we = 1'b1; b_addr = 9'd5; b_wdata = 16'hBEEF;
        smp;
        chk("raw_wgnt", {a_gnt, b_gnt}, 2'b01);
        tick;
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd5;
        smp;
        chk("raw_rgnt", {a_gnt, b_gnt}, 2'b10);
        tick;
        a_req = 1'b0;
        smp;
        chk("raw_data", {a_rvalid, a_rdata}, {1'b1, 16'hBEEF});

        // B-only write leaves last = B, then both contend for 6 cycles
        tick;
        b_req = 1'b1; b_we = 1'b1; b_addr = 9'd2; b_wdata = 16'h5555;
        smp;
        chk("pre_rr_gnt", {a_gnt, b_gnt}, 2'b01);
        tick;
        b_we = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd1;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            smp;
            pat = {pat[9:0], a_gnt, b_gnt};
            tick;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_pat", pat, 12'b10_01_10_01_10_01);
        smp;
        chk("rr_brd", {b_rvalid, b_rdata}, {1'b1, 16'h5555});

        // clear_start in the same cycle as a granted write to 511
        tick;
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'd511; a_wdata = 16'h00FF;
        clear_start = 1'b1;
        smp;
        chk("cs_gnt", {a_gnt, busy}, 2'b10);
        tick;
        clear_start = 1'b0;
        a_we = 1'b0;
        sweep("clr", 0);
        smp;
        chk("clr_done", {busy, a_gnt}, 2'b01);
        chk("mem_zero1", nz(), 0);
        tick;
        a_req = 1'b0;
        smp;
        chk("clr_rd511", {a_rvalid, a_rdata}, {1'b1, 16'h0000});

        // reset in the middle of the post-reset sweep
        tick;
        fill = 1'b1;
        tick;
        fill = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd7;
        repeat (201) @(posedge clk);
        #2;
        chk("mid_addr", {busy, ram_load, ram_address}, {2'b11, 9'd200});
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy, ram_load, a_gnt, b_gnt, a_rvalid, b_rvalid}, 6'b100000);
        chk("abort_addr", {ram_address, ram_in}, 0);
        chk("abort_rdata", {a_rdata, b_rdata}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep("sweep1", 1);
        smp;
        chk("mem_zero2", nz(), 0);
        chk("post_gnt", {busy, a_gnt}, 2'b01);
        tick;
        a_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-port arbiter and initialiser for the single-port ram512 (16-bit words, 9-bit address, `load` write strobe).
- After reset, it sweeps the whole RAM, writing zeros.
- It then shares the RAM between requester A and requester B, one access per cycle, using round-robin priority.
- It sits between the ram512 instance and its two clients, and is the only driver of ram512's `in`, `address` and `load`.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 9, RAM address width; depth = 2**ADDR_WIDTH = 512.
- CLEAR_ON_RESET, 1, 1 = zero-sweep after reset; 0 = go straight to RUN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear_start  input  1  one-cycle pulse requesting a full zero-sweep.
- busy  output  1  high while in START or CLEAR.
- a_req  input  1  requester A access request.
- a_we  input  1  A: 1 = write, 0 = read.
- a_addr  input  ADDR_WIDTH  A address.
- a_wdata  input  DATA_WIDTH  A write data.
- a_gnt  output  1  A access accepted at the end of this cycle (combinational).
- a_rdata  output  DATA_WIDTH  A read data (registered).
- a_rvalid  output  1  a_rdata valid, one-cycle pulse.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as A, for requester B.
- ram_in  output  DATA_WIDTH  to ram512 `in`.
- ram_address  output  ADDR_WIDTH  to ram512 `address`.
- ram_load  output  1  to ram512 `load`.
- ram_out  input  DATA_WIDTH  from ram512 `out`.

Behaviour:
- **Clock and reset:** one clock; reset is asynchronous and active-low (`rst_n`).
- **RAM timing contract:**
  - A write commits on the rising edge with `ram_load` = 1.
  - `ram_out` reflects `ram_address` combinationally within the same cycle.
- **Reset values:**
  - state = START, busy = 1.
  - a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0.
  - ram_load = 0, ram_address = 0, ram_in = 0.
  - clear counter = 0; round-robin pointer `last` = B, so A wins first.
- **FSM, START:**
  - Lasts one cycle; no RAM access.
  - Next state is CLEAR if CLEAR_ON_RESET = 1, else RUN.
- **FSM, CLEAR:**
  - Each cycle: ram_load = 1, ram_in = 0, ram_address = counter; counter increments.
  - The cycle that writes address 511 transitions to RUN and resets the counter to 0.
  - A sweep takes exactly 512 cycles; busy = 1 throughout.
  - No grants are issued; requests stay pending and are not lost.
- **FSM, RUN:**
  - busy = 0.
  - clear_start = 1 moves the FSM to CLEAR at the next edge. In that same cycle normal arbitration still happens, so one grant may be issued.
  - clear_start is ignored while already in START or CLEAR.
- **Arbitration (RUN only), each cycle:**
  - Only a_req: grant A. Only b_req: grant B.
  - Both requesting: grant the requester that is not `last`.
  - `last` updates only on a grant.
  - At most one gnt is high per cycle; gnt is never high while req is low.
- **Access:**
  - The winner's addr, wdata and we drive ram_address, ram_in and ram_load combinationally.
  - With no winner: ram_load = 0 and ram_address holds its last driven value, so no spurious write occurs.
- **Handshake:**
  - The requester holds req, we, addr and wdata stable until it sees gnt = 1.
  - The transaction completes at the edge ending the gnt cycle.
  - req still high in the following cycle is a new request.
- **Reads:**
  - On the edge ending a granted read, x_rdata ← ram_out and x_rvalid = 1 for exactly one cycle (latency 1).
  - x_rdata holds its value until the next read by that requester.
- **Writes:** no rvalid pulse.
- **Same-address conflict:** A write granted in cycle N is visible to a read of the same address granted in cycle N+1.
- **Reset mid-operation:** asserting rst_n mid-sweep or mid-transaction aborts it immediately. On release, the block restarts from START with a full sweep; no partial state survives.

Test Plan:
- **Post-reset sweep:** release rst_n with CLEAR_ON_RESET = 1 and a_req held high. Required: busy = 1 for 513 cycles (START + 512), ram_load = 1 on all 512 CLEAR cycles covering addresses 0..511 with ram_in = 0, a_gnt = 0 throughout, then a_gnt = 1 on the first RUN cycle.
- **Write then read, single requester:** A writes 16'h1234 to address 9'd300, then reads 9'd300. Required: a_rvalid pulses one cycle after the read grant with a_rdata = 16'h1234; b_rvalid stays 0.
- **Contention round-robin:** A and B both request continuously for 6 cycles. Required: grants alternate A, B, A, B, A, B; never both in one cycle.
- **Read-after-write across requesters:** B writes 16'hBEEF to 9'd5 in cycle N; A reads 9'd5 in cycle N+1. Required: a_rdata = 16'hBEEF and a_rvalid = 1 in cycle N+2.
- **clear_start in RUN:** pulse clear_start after writing 16'h00FF to 9'd511. Required: busy high for 512 cycles, no grants during CLEAR, and a subsequent read of 9'd511 returns 16'h0000.
- **Reset mid-sweep:** assert rst_n low at sweep count 200. Required: all outputs immediately return to reset values, and after release a full 512-cycle sweep restarts from address 0.
